// File: rtl/regfile_writeback_pkg.sv
// Shared widths, default queue depth and the queued write entry type
// for the register-file writeback buffer.
package regfile_writeback_pkg;

    localparam int REG_AW   = 5;
    localparam int REG_DW   = 32;
    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic [REG_AW-1:0] da;
        logic [REG_DW-1:0] d;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// In-order write queue with wrapping pointers; exposes per-entry valid/da so
// the top level can detect read-after-write hazards against pending writes.
module wb_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             push,
    input  wb_entry_t                        wdata,
    input  logic                             pop,
    output wb_entry_t                        head,
    output logic [$clog2(DEPTH):0]           count,
    output logic [DEPTH-1:0]                 ent_valid,
    output logic [DEPTH-1:0][REG_AW-1:0]     ent_da
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    offset;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push && !reset && !flush) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        offset    = '0;
        ent_valid = '0;
        ent_da    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset       = AW'(i) - rd_ptr;
            ent_valid[i] = ({1'b0, offset} < count);
            ent_da[i]    = mem[i].da;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback buffer between execute results and the register-file write port:
// filters non-writes, queues in order, drains one entry per available slot.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_we,
    input  logic [REG_AW-1:0]          in_da,
    input  logic [REG_DW-1:0]          in_d,
    input  logic                       wb_en,
    input  logic                       flush,
    output logic                       RL,
    output logic [REG_AW-1:0]          DA,
    output logic [REG_DW-1:0]          D,
    input  logic [REG_AW-1:0]          AA,
    input  logic [REG_AW-1:0]          BA,
    output logic                       hazard_a,
    output logic                       hazard_b,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t                  head;
    logic                       accept;
    logic                       push;
    logic                       pop;
    logic [DEPTH-1:0]           ent_valid;
    logic [DEPTH-1:0][REG_AW-1:0] ent_da;
    logic                       hit_a;
    logic                       hit_b;

    // Handshake: a transfer happens at a rising edge where in_valid and
    // in_ready are both 1; in_valid never waits on in_ready, and in_ready
    // deasserts when the queue is full or a flush is in progress.
    assign in_ready = (count < CW'(DEPTH)) && !flush;
    assign accept   = in_valid && in_ready;
    // Writes to r0 and non-writes complete the handshake but are dropped.
    assign push     = accept && in_we && (in_da != '0);
    assign pop      = (count != '0) && wb_en && !flush;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .wdata     ('{da: in_da, d: in_d}),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .ent_valid (ent_valid),
        .ent_da    (ent_da)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            RL <= 1'b0;
            DA <= '0;
            D  <= '0;
        end else if (pop) begin
            RL <= 1'b1;
            DA <= head.da;
            D  <= head.d;
        end else begin
            RL <= 1'b0;
        end
    end

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && ent_da[i] == AA) hit_a = 1'b1;
            if (ent_valid[i] && ent_da[i] == BA) hit_b = 1'b1;
        end
    end

    // The entry being written this cycle still counts as pending.
    assign hazard_a = (AA != '0) && (hit_a || (RL && DA == AA));
    assign hazard_b = (BA != '0) && (hit_b || (RL && DA == BA));

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queued write entries (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  producer offers a write result.
REQ-005 SHALL have port in_ready  output  1  block can accept an offer this cycle.
REQ-006 SHALL have port in_we  input  1  offered result is a real register write.
REQ-007 SHALL have port in_da  input  5  destination register address.
REQ-008 SHALL have port in_d  input  32  destination data.
REQ-009 SHALL have port wb_en  input  1  register-file write port available this cycle.
REQ-010 SHALL have port flush  input  1  discard all pending writes.
REQ-011 SHALL have port RL  output  1  register-load strobe to the register file.
REQ-012 SHALL have port DA  output  5  register-file write address.
REQ-013 SHALL have port D  output  32  register-file write data.
REQ-014 SHALL have ports AA, BA  input  5 each  read addresses being issued by decode.
REQ-015 SHALL have ports hazard_a, hazard_b  output  1 each  a pending write targets AA/BA.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  number of queued entries.

Function
REQ-017 Handshake: transfer occurs on the rising edge where in_valid and in_ready are both 1; in_valid SHALL NOT depend on in_ready.
REQ-018 in_ready SHALL be 1 iff count < DEPTH and flush is 0 (no same-cycle full bypass).
REQ-019 A transfer with in_we=0 or in_da=0 SHALL complete the handshake but SHALL NOT be enqueued.
REQ-020 Queue SHALL be in-order FIFO; entries are {da, d}.
REQ-021 Drain: at each edge where count>0, wb_en=1 and flush=0, head SHALL be popped and RL<=1, DA<=head.da, D<=head.d; otherwise RL<=0 and DA/D hold their values.
REQ-022 RL SHALL be high for exactly one cycle per popped entry; back-to-back pops give consecutive RL pulses.
REQ-023 Latency: entry accepted into empty queue at edge k with wb_en=1 SHALL be popped at edge k+1; RL high between edges k+1 and k+2.
REQ-024 Simultaneous enqueue and pop at one edge SHALL leave count unchanged; a pop and enqueue at count=DEPTH-1 is legal.
REQ-025 Pointers SHALL wrap modulo DEPTH; count distinguishes full from empty.
REQ-026 flush=1 at an edge SHALL empty the queue, set RL<=0, and take priority over enqueue and pop.
REQ-027 hazard_a SHALL be combinational: 1 iff AA!=0 and AA matches da of any valid queued entry or (RL=1 and DA=AA); hazard_b likewise for BA.
REQ-028 wb_en=0 with a full queue SHALL hold all entries and in_ready=0 indefinitely without loss.

Reset
REQ-029 reset=1 at an edge SHALL set count=0, pointers=0, RL=0, DA=0, D=0; hazard outputs then 0.
REQ-030 reset mid-operation SHALL discard queued entries and any RL pulse in progress; reset has priority over flush, enqueue, pop.
REQ-031 Queue storage contents need not be reset; only valid state is.

Structure
REQ-032 Shared package SHALL hold REG_AW=5, REG_DW=32, default WB_DEPTH=4 and the entry struct {da, d}.
REQ-033 Storage and pointers SHALL be a sub-module wb_fifo exposing per-entry valid/da for hazard compare; top holds handshake, output register, hazard logic.

Verification
REQ-034 Single write: reset, in_we=1, in_da=3, in_d=0x0000_00AA, wb_en=1 -> RL=1, DA=3, D=0xAA exactly one cycle, two edges after acceptance.
REQ-035 R0/no-write filter: in_da=0 (we=1) then in_we=0 (da=5) -> both handshakes complete, RL never asserts, count stays 0.
REQ-036 Full/backpressure: wb_en=0, offer 5 writes (da 1..5) -> in_ready=0 after 4, count=4; raise wb_en -> RL pulses da 1,2,3,4 then 5 in order, consecutive.
REQ-037 Hazard: queue da=7, AA=7, BA=8 -> hazard_a=1, hazard_b=0; after RL pulse for da=7 ends -> hazard_a=0.
REQ-038 Flush/reset mid-drain: 3 queued, assert flush during first RL pulse -> RL=0 next cycle, count=0, no further pulses; repeat with reset -> same plus DA=0, D=0.
REQ-039 Wrap: 10 consecutive writes with wb_en=1 and in_valid held -> data order preserved across pointer wrap, count never exceeds 2.
